repetition_memory_scrubber: RTL and testbench
=============================================

Name: repetition_memory_scrubber

Overview:
Background scrubber for a memory that stores repetition-encoded words, where each word is REPETITION concatenated copies of DATA_WIDTH bits.
- Walks every address in turn.
- Reads each block and majority-votes it.
- Writes the corrected re-replicated block back when any copy disagrees.
- Reports error events and keeps an error count.
- Sits beside the functional memory port and shares it through a request/grant handshake with an external arbiter.

Parameters:
DATA_WIDTH, 8, bits per copy.
REPETITION, 3, copies per block (≥2). Even values resolve vote ties to 0.
DEPTH, 16, number of words scrubbed (≥2).
ADDRESS_WIDTH, $clog2(DEPTH), address width.
SCRUB_INTERVAL, 256, idle cycles between word scrubs. 0 means back-to-back.
COUNTER_WIDTH, 16, width of the error counter.

Ports:
clock  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  1  scrubbing enabled
memory_request  output  1  scrubber wants the port
memory_grant  input  1  port given to scrubber this cycle
memory_write  output  1  1 = write, 0 = read (valid with memory_request)
memory_address  output  ADDRESS_WIDTH  access address
memory_write_block  output  REPETITION*DATA_WIDTH  block to write
memory_read_block  input  REPETITION*DATA_WIDTH  read data, valid 1 cycle after a granted read
snoop_write_valid  input  1  functional write occurring this cycle
snoop_write_address  input  ADDRESS_WIDTH  address of that functional write
clear_count  input  1  synchronous clear of error_count
error_detected  output  1  1-cycle pulse: scrubbed block had disagreeing copies
error_address  output  ADDRESS_WIDTH  address of the last error (held)
error_count  output  COUNTER_WIDTH  saturating count of error events
pass_done  output  1  1-cycle pulse when the last address finishes
busy  output  1  high in READ, CHECK or WRITE

Behaviour:
Reset:
- All outputs 0.
- Scrub address 0, FSM in IDLE, interval counter loaded with SCRUB_INTERVAL.

FSM states and transitions:
- IDLE → WAIT when enable=1.
- WAIT decrements the interval counter each cycle. When it is 0 → READ and the counter reloads. Interval 0 gives a single pass through WAIT.
- enable=0 in WAIT → IDLE.
- enable=0 in READ, CHECK or WRITE does not abort: the current word completes, then the FSM returns to IDLE.
- READ holds memory_request=1, memory_write=0 and the address until the cycle memory_grant=1, then → CHECK.
- CHECK (the cycle after the granted read) samples memory_read_block.
  - Per bit, the voted value is 1 iff the number of ones > REPETITION/2 (integer division).
  - A bit is in error iff its copies are not unanimous.
  - Any bit in error: pulse error_detected, latch error_address, increment error_count (saturating at all-ones), then → WRITE with memory_write_block = voted data replicated REPETITION times (copy k at bits [k*DATA_WIDTH +: DATA_WIDTH]).
  - No error: advance to the next address.
- WRITE holds memory_request=1, memory_write=1 until granted, then advances to the next address.

Snoop cancel:
- If snoop_write_valid=1 with snoop_write_address equal to the scrub address in any cycle from the granted read through WRITE (grant cycle included), the pending writeback is cancelled.
- The FSM then advances without writing, because the functional data is newer.
- The error is still counted.

Advance:
- Address increments. From DEPTH-1 it wraps to 0 and pass_done pulses in the same cycle.
- Next state is WAIT if enable=1, else IDLE.

Simultaneous events:
- clear_count together with an increment gives error_count = 1.
- clear_count alone gives 0.

Other rules:
- memory_request never drops while waiting for a grant.
- The address and memory_write_block are stable while memory_request=1.
- Grant asserted while memory_request=0 is ignored.
- Asynchronous reset mid-operation returns to the reset state immediately. No write is issued afterwards.

Test Plan:
- Defaults with SCRUB_INTERVAL=0, DEPTH=4, memory preloaded with 0xA5A5A5 at all addresses, enable=1, grant always 1 → four reads, no writes, pass_done pulses once per 4 words, error_count stays 0.
- Address 2 holds 0xA5A5A4 (one copy's bit0 flipped) → error_detected pulse, error_address=2, error_count=1, write of 0xA5A5A5 to address 2. Next pass reports no error.
- Address 1 holds 0xFF00FF → writeback 0xFFFFFF. With REPETITION=2 and block 0xFF00 → writeback 0x0000 (tie resolves to 0).
- memory_grant held 0 for 5 cycles in READ, then in WRITE → memory_request, address and write block stable throughout; the access happens exactly on the grant cycle.
- Corrupt address 3 and assert snoop_write_valid with address 3 during CHECK → no write issued, error_count still increments, scrubbing resumes at address 0.
- COUNTER_WIDTH=2 with 5 corrupted words → error_count saturates at 3. clear_count in the same cycle as a new error → error_count=1. resetn pulsed low during WRITE → all outputs 0, no write.

Source files
------------

// File: rtl/repetition_memory_scrubber.sv
// repetition_memory_scrubber
//   Background scrubber for a memory whose words hold REPETITION copies of a
//   DATA_WIDTH-bit value. It walks the address space, reads each block,
//   majority-votes it and writes the corrected block back when any copy
//   disagrees. The memory port is shared with the functional path through a
//   request/grant handshake. Functional writes are snooped so that a stale
//   writeback never overwrites newer data.
//
// Ports
//   clock, resetn         clock, asynchronous active-low reset
//   enable                scrubbing enabled
//   memory_request/grant  port handshake (grant ignored without request)
//   memory_write          1 = write, 0 = read (valid with memory_request)
//   memory_address        access address (scrub pointer)
//   memory_write_block    corrected block for the writeback
//   memory_read_block     read data, valid the cycle after a granted read
//   snoop_write_*         functional write observed on the port
//   clear_count           synchronous clear of error_count
//   error_detected        1-cycle pulse per block with disagreeing copies
//   error_address         address of the most recent error (held)
//   error_count           saturating error event counter
//   pass_done             1-cycle pulse when the pointer wraps to 0
//   busy                  high in READ, CHECK or WRITE

// Per-bit vote across REPETITION copies. Ties (even REPETITION) resolve to 0.
module repetition_bit_vote #(
    parameter int REPETITION = 3
) (
    input  logic [REPETITION-1:0] copies,
    output logic                  voted,
    output logic                  mismatch
);
    localparam int CW = $clog2(REPETITION + 1);

    logic [CW-1:0] ones;

    always_comb begin
        ones = '0;
        for (int k = 0; k < REPETITION; k++) begin
            ones = ones + {{(CW-1){1'b0}}, copies[k]};
        end
    end

    assign voted    = (ones > CW'(REPETITION / 2));
    assign mismatch = !(&copies) && (|copies);
endmodule

module repetition_memory_scrubber #(
    parameter int DATA_WIDTH     = 8,
    parameter int REPETITION     = 3,
    parameter int DEPTH          = 16,
    parameter int ADDRESS_WIDTH  = $clog2(DEPTH),
    parameter int SCRUB_INTERVAL = 256,
    parameter int COUNTER_WIDTH  = 16
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             enable,
    output logic                             memory_request,
    input  logic                             memory_grant,
    output logic                             memory_write,
    output logic [ADDRESS_WIDTH-1:0]         memory_address,
    output logic [REPETITION*DATA_WIDTH-1:0] memory_write_block,
    input  logic [REPETITION*DATA_WIDTH-1:0] memory_read_block,
    input  logic                             snoop_write_valid,
    input  logic [ADDRESS_WIDTH-1:0]         snoop_write_address,
    input  logic                             clear_count,
    output logic                             error_detected,
    output logic [ADDRESS_WIDTH-1:0]         error_address,
    output logic [COUNTER_WIDTH-1:0]         error_count,
    output logic                             pass_done,
    output logic                             busy
);
    localparam int BW = REPETITION * DATA_WIDTH;
    localparam int IW = (SCRUB_INTERVAL > 0) ? $clog2(SCRUB_INTERVAL + 1) : 1;
    localparam logic [IW-1:0]            RELOAD    = IW'(SCRUB_INTERVAL);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_CHECK,
        ST_WRITE
    } state_t;

    state_t                     state, state_nxt;
    logic [ADDRESS_WIDTH-1:0]   addr, addr_nxt;
    logic [IW-1:0]              icnt, icnt_nxt;
    logic                       cancel_q, cancel_nxt;
    logic [BW-1:0]              wblk, wblk_nxt;
    logic                       err_det_nxt;
    logic [ADDRESS_WIDTH-1:0]   err_addr, err_addr_nxt;
    logic [COUNTER_WIDTH-1:0]   err_cnt, err_cnt_nxt;
    logic                       pass_nxt;
    logic                       inc;
    logic                       advance;

    logic [DATA_WIDTH-1:0]      voted;
    logic [DATA_WIDTH-1:0]      bit_err;
    logic                       snoop_hit;

    // Vote each bit position across its copies.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_vote
        logic [REPETITION-1:0] bit_copies;
        for (genvar k = 0; k < REPETITION; k++) begin : g_copy
            assign bit_copies[k] = memory_read_block[k*DATA_WIDTH + b];
        end
        repetition_bit_vote #(.REPETITION(REPETITION)) u_vote (
            .copies  (bit_copies),
            .voted   (voted[b]),
            .mismatch(bit_err[b])
        );
    end

    assign snoop_hit = snoop_write_valid && (snoop_write_address == addr);

    // A snoop hit during WRITE abandons the writeback in that same cycle so
    // a coincident grant cannot push stale data over the functional write.
    assign memory_request     = (state == ST_READ) || ((state == ST_WRITE) && !snoop_hit);
    assign memory_write       = (state == ST_WRITE);
    assign memory_address     = addr;
    assign memory_write_block = wblk;
    assign error_address      = err_addr;
    assign error_count        = err_cnt;
    assign busy               = (state == ST_READ) || (state == ST_CHECK) || (state == ST_WRITE);

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        icnt_nxt     = icnt;
        cancel_nxt   = cancel_q;
        wblk_nxt     = wblk;
        err_det_nxt  = 1'b0;
        err_addr_nxt = err_addr;
        pass_nxt     = 1'b0;
        inc          = 1'b0;
        advance      = 1'b0;

        case (state)
            ST_IDLE: begin
                icnt_nxt   = RELOAD;
                cancel_nxt = 1'b0;
                if (enable) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                    icnt_nxt  = RELOAD;
                end else if (icnt == '0) begin
                    state_nxt = ST_READ;
                    icnt_nxt  = RELOAD;
                end else begin
                    icnt_nxt = icnt - IW'(1);
                end
            end
            ST_READ: begin
                if (memory_grant) begin
                    cancel_nxt = snoop_hit;
                    state_nxt  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (|bit_err) begin
                    err_det_nxt  = 1'b1;
                    err_addr_nxt = addr;
                    inc          = 1'b1;
                    if (cancel_q || snoop_hit) begin
                        advance = 1'b1;
                    end else begin
                        wblk_nxt  = {REPETITION{voted}};
                        state_nxt = ST_WRITE;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            ST_WRITE: begin
                if (snoop_hit || memory_grant) advance = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (advance) begin
            cancel_nxt = 1'b0;
            pass_nxt   = (addr == LAST_ADDR);
            addr_nxt   = (addr == LAST_ADDR) ? '0 : addr + ADDRESS_WIDTH'(1);
            state_nxt  = enable ? ST_WAIT : ST_IDLE;
        end

        // Clear takes effect first; a coincident new error still counts.
        if (clear_count) begin
            err_cnt_nxt = inc ? COUNTER_WIDTH'(1) : '0;
        end else if (inc && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + COUNTER_WIDTH'(1);
        end else begin
            err_cnt_nxt = err_cnt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            addr           <= '0;
            icnt           <= RELOAD;
            cancel_q       <= 1'b0;
            wblk           <= '0;
            error_detected <= 1'b0;
            err_addr       <= '0;
            err_cnt        <= '0;
            pass_done      <= 1'b0;
        end else begin
            state          <= state_nxt;
            addr           <= addr_nxt;
            icnt           <= icnt_nxt;
            cancel_q       <= cancel_nxt;
            wblk           <= wblk_nxt;
            error_detected <= err_det_nxt;
            err_addr       <= err_addr_nxt;
            err_cnt        <= err_cnt_nxt;
            pass_done      <= pass_nxt;
        end
    end
endmodule

// File: tb/tb_repetition_memory_scrubber.sv
// Directed bench for repetition_memory_scrubber. Main instance: 3 copies of
// 8 bits, 4 words, no interval, 2-bit counter. Second instance: 2 copies,
// 2 words, for the even-repetition tie rule. Inputs change 1 time unit
// after the rising edge; outputs are observed on the falling edge.
module tb_repetition_memory_scrubber;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        memory_grant = 1'b0;
    logic        snoop_write_valid = 1'b0;
    logic [1:0]  snoop_write_address = '0;
    logic        clear_count = 1'b0;
    logic        memory_request, memory_write, error_detected, pass_done, busy;
    logic [1:0]  memory_address, error_address, error_count;
    logic [23:0] memory_write_block;
    logic [23:0] rd_data = '0;

    logic        enable2 = 1'b0;
    logic        grant2 = 1'b1;
    logic        snoop2_valid = 1'b0;
    logic [0:0]  snoop2_address = '0;
    logic        clear2 = 1'b0;
    logic        memory_request2, memory_write2, error_detected2, pass_done2, busy2;
    logic [0:0]  memory_address2, error_address2;
    logic [3:0]  error_count2;
    logic [15:0] memory_write_block2;
    logic [15:0] rd_data2 = '0;

    logic [23:0] mem [4];
    logic [15:0] mem2 [2];
    logic        load_en = 1'b0, load_sel = 1'b0;
    logic [1:0]  load_addr = '0;
    logic [23:0] load_data = '0;

    int rd_cnt = 0, wr_cnt = 0, err_seen = 0, pass_cnt = 0;
    int wr2_cnt = 0, err2_seen = 0, pass2_cnt = 0;
    logic [1:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic [0:0]  wr2_addr = '0;
    logic [15:0] wr2_data = '0;

    int n_checks = 0;
    int n_fail = 0;

    repetition_memory_scrubber #(
        .DATA_WIDTH(8), .REPETITION(3), .DEPTH(4), .SCRUB_INTERVAL(0), .COUNTER_WIDTH(2)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable),
        .memory_request(memory_request), .memory_grant(memory_grant),
        .memory_write(memory_write), .memory_address(memory_address),
        .memory_write_block(memory_write_block), .memory_read_block(rd_data),
        .snoop_write_valid(snoop_write_valid), .snoop_write_address(snoop_write_address),
        .clear_count(clear_count), .error_detected(error_detected),
        .error_address(error_address), .error_count(error_count),
        .pass_done(pass_done), .busy(busy)
    );

    repetition_memory_scrubber #(
        .DATA_WIDTH(8), .REPETITION(2), .DEPTH(2), .SCRUB_INTERVAL(0), .COUNTER_WIDTH(4)
    ) dut2 (
        .clock(clock), .resetn(resetn), .enable(enable2),
        .memory_request(memory_request2), .memory_grant(grant2),
        .memory_write(memory_write2), .memory_address(memory_address2),
        .memory_write_block(memory_write_block2), .memory_read_block(rd_data2),
        .snoop_write_valid(snoop2_valid), .snoop_write_address(snoop2_address),
        .clear_count(clear2), .error_detected(error_detected2),
        .error_address(error_address2), .error_count(error_count2),
        .pass_done(pass_done2), .busy(busy2)
    );

    always #5 clock = ~clock;

    // Memory models
    always @(posedge clock) begin
        if (load_en) begin
            if (load_sel) mem2[load_addr[0]] <= load_data[15:0];
            else          mem[load_addr]     <= load_data;
        end
        if (memory_request && memory_grant) begin
            if (memory_write) mem[memory_address] <= memory_write_block;
            else              rd_data <= mem[memory_address];
        end
        if (memory_request2 && grant2) begin
            if (memory_write2) mem2[memory_address2] <= memory_write_block2;
            else               rd_data2 <= mem2[memory_address2];
        end
    end

    // Event monitor
    always @(negedge clock) begin
        if (memory_request && memory_grant) begin
            if (memory_write) begin
                wr_cnt++; wr_addr = memory_address; wr_data = memory_write_block;
            end else begin
                rd_cnt++;
            end
        end
        if (error_detected) err_seen++;
        if (pass_done) pass_cnt++;
        if (memory_request2 && grant2 && memory_write2) begin
            wr2_cnt++; wr2_addr = memory_address2; wr2_data = memory_write_block2;
        end
        if (error_detected2) err2_seen++;
        if (pass_done2) pass2_cnt++;
    end

    task automatic mem_load(input logic sel, input logic [1:0] a, input logic [23:0] d);
        @(posedge clock); #1;
        load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
        @(posedge clock); #1;
        load_en = 1'b0;
    endtask

    // Reset both instances, preload the main memory, release with enables low.
    task automatic do_reset(input logic [23:0] d0, d1, d2, d3);
        @(posedge clock); #1;
        resetn = 1'b0; enable = 1'b0; enable2 = 1'b0; memory_grant = 1'b1;
        snoop_write_valid = 1'b0; clear_count = 1'b0;
        mem_load(1'b0, 2'd0, d0);
        mem_load(1'b0, 2'd1, d1);
        mem_load(1'b0, 2'd2, d2);
        mem_load(1'b0, 2'd3, d3);
        resetn = 1'b1;
    endtask

    // kind 0: pass_done, 1: CHECK at address a, 2: request, 3: write, 4: pass_done2
    task automatic wait_for(input int kind, input logic [1:0] a, output bit ok);
        logic hit;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock); #1;
            case (kind)
                0: hit = pass_done;
                1: hit = busy && !memory_request && (memory_address == a);
                2: hit = memory_request;
                3: hit = memory_write;
                default: hit = pass_done2;
            endcase
            if (hit) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if ({memory_request, memory_write, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {memory_request, memory_write, busy}); end
        n_checks++; if (memory_address !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", memory_address); end
        n_checks++; if (memory_write_block !== 24'h0) begin n_fail++; $display("FAIL reset_wblk: got %h expected 000000", memory_write_block); end
        n_checks++; if ({error_detected, pass_done, error_address, error_count} !== 6'b0) begin n_fail++; $display("FAIL reset_status: got %b expected 000000", {error_detected, pass_done, error_address, error_count}); end
    endtask

    task automatic test_clean_pass();
        bit ok;
        int r0, w0, e0, p0;
        do_reset(24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5);
        r0 = rd_cnt; w0 = wr_cnt; e0 = err_seen; p0 = pass_cnt;
        enable = 1'b1;
        wait_for(0, 2'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clean_pass1_timeout: got none expected pass_done"); end
        n_checks++; if (rd_cnt - r0 !== 4) begin n_fail++; $display("FAIL clean_reads1: got %0d expected 4", rd_cnt - r0); end
        n_checks++; if (memory_address !== 2'd0) begin n_fail++; $display("FAIL clean_wrap_addr: got %0d expected 0", memory_address); end
        wait_for(0, 2'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clean_pass2_timeout: got none expected pass_done"); end
        n_checks++; if (rd_cnt - r0 !== 8) begin n_fail++; $display("FAIL clean_reads2: got %0d expected 8", rd_cnt - r0); end
        n_checks++; if (pass_cnt - p0 !== 2) begin n_fail++; $display("FAIL clean_pass_pulses: got %0d expected 2", pass_cnt - p0); end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL clean_writes: got %0d expected 0", wr_cnt - w0); end
        n_checks++; if ({err_seen - e0, 32'(error_count)} !== 64'd0) begin n_fail++; $display("FAIL clean_errors: got pulses %0d count %0d expected 0 0", err_seen - e0, error_count); end
    endtask

    task automatic test_single_error();
        bit ok;
        int w0, e0;
        do_reset(24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A4, 24'hA5A5A5);
        w0 = wr_cnt; e0 = err_seen;
        enable = 1'b1;
        wait_for(0, 2'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got none expected pass_done"); end
        n_checks++; if (err_seen - e0 !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", err_seen - e0); end
        n_checks++; if (error_address !== 2'd2) begin n_fail++; $display("FAIL single_err_addr: got %0d expected 2", error_address); end
        n_checks++; if (error_count !== 2'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", error_count); end
        n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL single_writes: got %0d expected 1", wr_cnt - w0); end
        n_checks++; if ({wr_addr, wr_data} !== {2'd2, 24'hA5A5A5}) begin n_fail++; $display("FAIL single_wb: got %0d/%h expected 2/a5a5a5", wr_addr, wr_data); end
        wait_for(0, 2'd0, ok);
        n_checks++; if (!ok || (err_seen - e0 !== 1) || (wr_cnt - w0 !== 1)) begin n_fail++; $display("FAIL single_second_pass: got pulses %0d writes %0d expected 1 1", err_seen - e0, wr_cnt - w0); end
    endtask

    task automatic test_majority();
        bit ok;
        int w0, w20, e20;
        do_reset(24'hA5A5A5, 24'hFF00FF, 24'hA5A5A5, 24'hA5A5A5);
        mem_load(1'b1, 2'd0, 24'h005555);
        mem_load(1'b1, 2'd1, 24'h00FF00);
        w0 = wr_cnt; w20 = wr2_cnt; e20 = err2_seen;
        enable = 1'b1; enable2 = 1'b1;
        wait_for(4, 2'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tie_timeout: got none expected pass_done2"); end
        n_checks++; if ((wr2_cnt - w20 !== 1) || (err2_seen - e20 !== 1)) begin n_fail++; $display("FAIL tie_events: got writes %0d pulses %0d expected 1 1", wr2_cnt - w20, err2_seen - e20); end
        n_checks++; if ({wr2_addr, wr2_data} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL tie_wb: got %0d/%h expected 1/0000", wr2_addr, wr2_data); end
        enable2 = 1'b0;
        wait_for(0, 2'd0, ok);
        n_checks++; if (!ok || (wr_cnt - w0 !== 1)) begin n_fail++; $display("FAIL major_writes: got %0d expected 1", wr_cnt - w0); end
        n_checks++; if ({wr_addr, wr_data} !== {2'd1, 24'hFFFFFF}) begin n_fail++; $display("FAIL major_wb: got %0d/%h expected 1/ffffff", wr_addr, wr_data); end
    endtask

    task automatic test_grant_hold();
        bit ok;
        int r0, w0;
        do_reset(24'hA5A5A4, 24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5);
        memory_grant = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        enable = 1'b1;
        wait_for(2, 2'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_req_timeout: got none expected request"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            n_checks++; if ({memory_request, memory_write, memory_address} !== 4'b1000) begin n_fail++; $display("FAIL hold_read_stable: got %b expected 1000", {memory_request, memory_write, memory_address}); end
        end
        n_checks++; if (rd_cnt - r0 !== 0) begin n_fail++; $display("FAIL hold_read_early: got %0d expected 0", rd_cnt - r0); end
        @(posedge clock); #1; memory_grant = 1'b1;
        @(posedge clock); #1; memory_grant = 1'b0;
        n_checks++; if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL hold_read_once: got %0d expected 1", rd_cnt - r0); end
        wait_for(3, 2'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_write_timeout: got none expected write"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            n_checks++; if ({memory_request, memory_write, memory_address, memory_write_block} !== {4'b1100, 24'hA5A5A5}) begin n_fail++; $display("FAIL hold_write_stable: got %b/%h expected 1100/a5a5a5", {memory_request, memory_write, memory_address}, memory_write_block); end
        end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL hold_write_early: got %0d expected 0", wr_cnt - w0); end
        @(posedge clock); #1; memory_grant = 1'b1;
        @(posedge clock); #1; memory_grant = 1'b0;
        @(negedge clock); #1;
        n_checks++; if ((wr_cnt - w0 !== 1) || (wr_addr !== 2'd0) || memory_write) begin n_fail++; $display("FAIL hold_write_once: got writes %0d addr %0d wr %b expected 1 0 0", wr_cnt - w0, wr_addr, memory_write); end
        memory_grant = 1'b1;
    endtask

    task automatic test_snoop_cancel();
        bit ok;
        int w0, e0, r0;
        do_reset(24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A4);
        w0 = wr_cnt; e0 = err_seen;
        enable = 1'b1;
        wait_for(1, 2'd3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL snoop_check_timeout: got none expected CHECK at 3"); end
        snoop_write_valid = 1'b1; snoop_write_address = 2'd3;
        @(posedge clock); #1; snoop_write_valid = 1'b0;
        wait_for(0, 2'd0, ok);
        n_checks++; if (!ok || (memory_address !== 2'd0)) begin n_fail++; $display("FAIL snoop_wrap: got addr %0d expected 0", memory_address); end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL snoop_no_write: got %0d expected 0", wr_cnt - w0); end
        n_checks++; if ((error_count !== 2'd1) || (err_seen - e0 !== 1) || (error_address !== 2'd3)) begin n_fail++; $display("FAIL snoop_counted: got count %0d pulses %0d addr %0d expected 1 1 3", error_count, err_seen - e0, error_address); end
        r0 = rd_cnt;
        wait_for(1, 2'd0, ok);
        n_checks++; if (!ok || (rd_cnt - r0 !== 1)) begin n_fail++; $display("FAIL snoop_resume: got reads %0d expected 1 at addr 0", rd_cnt - r0); end
    endtask

    task automatic test_saturate_clear();
        bit ok;
        int e0;
        do_reset(24'hA5A5A4, 24'h01A5A5, 24'hA5A4A5, 24'hA5A5A4);
        e0 = err_seen;
        enable = 1'b1;
        wait_for(0, 2'd0, ok);
        n_checks++; if (!ok || (err_seen - e0 !== 4)) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 4", err_seen - e0); end
        n_checks++; if (error_count !== 2'd3) begin n_fail++; $display("FAIL sat_count: got %0d expected 3", error_count); end
        mem_load(1'b0, 2'd2, 24'hA5A5A4);
        wait_for(1, 2'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clr_check_timeout: got none expected CHECK at 2"); end
        clear_count = 1'b1;
        @(posedge clock); #1; clear_count = 1'b0;
        @(negedge clock); #1;
        n_checks++; if (error_count !== 2'd1) begin n_fail++; $display("FAIL clear_with_error: got %0d expected 1", error_count); end
        @(posedge clock); #1; clear_count = 1'b1;
        @(posedge clock); #1; clear_count = 1'b0;
        @(negedge clock); #1;
        n_checks++; if (error_count !== 2'd0) begin n_fail++; $display("FAIL clear_alone: got %0d expected 0", error_count); end
    endtask

    task automatic test_reset_in_write();
        bit ok;
        int w0;
        do_reset(24'h5A5A5B, 24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5);
        memory_grant = 1'b0;
        enable = 1'b1;
        wait_for(2, 2'd0, ok);
        @(posedge clock); #1; memory_grant = 1'b1;
        @(posedge clock); #1; memory_grant = 1'b0;
        wait_for(3, 2'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_write_timeout: got none expected write"); end
        w0 = wr_cnt;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if ({memory_request, memory_write, busy, error_detected, pass_done} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b expected 00000", {memory_request, memory_write, busy, error_detected, pass_done}); end
        n_checks++; if ({memory_address, error_address, error_count, memory_write_block} !== 30'b0) begin n_fail++; $display("FAIL rst_mid_data: got %0d %0d %0d %h expected zeros", memory_address, error_address, error_count, memory_write_block); end
        memory_grant = 1'b1; enable = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        n_checks++; if ((wr_cnt - w0 !== 0) || busy) begin n_fail++; $display("FAIL rst_no_write: got writes %0d busy %b expected 0 0", wr_cnt - w0, busy); end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_single_error();
        test_majority();
        test_grant_hold();
        test_snoop_cancel();
        test_saturate_clear();
        test_reset_in_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
